// File: rtl/farm_pkg.sv
// Shared types and constants for the farm program loader.
package farm_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HDR_LO,
    LD_HDR_HI,
    LD_DATA,
    LD_WRITE,
    LD_DONE,
    LD_ERR
  } loader_state_t;

  localparam int LD_BYTES_PER_WORD = 4;

endpackage

// File: rtl/farm_word_packer.sv
// Collects bytes little-endian into a 32-bit word.
// The word output already merges the byte on byte_in so the top can register it on the 4th accept.
module farm_word_packer
  import farm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  logic [1:0]  lane;
  logic [31:0] data;

  assign full = (lane == 2'(LD_BYTES_PER_WORD - 1));

  always_comb begin
    word = data;
    word[8*lane +: 8] = byte_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      lane <= '0;
      data <= '0;
    end else if (load_en) begin
      data[8*lane +: 8] <= byte_in;
      lane <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/farm_imem_loader.sv
// Length-prefixed byte-stream loader writing 32-bit words into instruction memory.
// Holds the core in reset until a complete load has been written.
module farm_imem_loader
  import farm_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              err
);

  loader_state_t state, next;
  logic [7:0]    cnt_lo;
  logic [15:0]   cnt;
  logic [15:0]   hdr_cnt;
  logic [ADDR_W:0] word_idx;
  logic          accept;
  logic          pk_clear;
  logic          pk_load;
  logic          pk_full;
  logic [31:0]   pk_word;

  assign accept   = byte_valid && byte_ready;
  assign hdr_cnt  = {byte_in, cnt_lo};
  assign pk_clear = (state == LD_HDR_HI) && accept;
  assign pk_load  = (state == LD_DATA) && accept;

  farm_word_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pk_clear),
    .load_en (pk_load),
    .byte_in (byte_in),
    .word    (pk_word),
    .full    (pk_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LD_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      LD_IDLE:   if (start) next = LD_HDR_LO;
      LD_HDR_LO: if (accept) next = LD_HDR_HI;
      LD_HDR_HI: begin
        if (accept) begin
          if (hdr_cnt == 16'd0)                    next = LD_DONE;
          else if ({1'b0, hdr_cnt} > 17'(DEPTH))   next = LD_ERR;
          else                                     next = LD_DATA;
        end
      end
      LD_DATA:   if (accept && pk_full) next = LD_WRITE;
      LD_WRITE:  next = (17'(word_idx) + 17'd1 == {1'b0, cnt}) ? LD_DONE : LD_DATA;
      LD_DONE,
      LD_ERR:    if (start) next = LD_HDR_LO;
      default:   next = LD_IDLE;
    endcase
  end

  // Handshake, strobe and write bus are registered off the next state so they
  // line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cnt_lo     <= '0;
      cnt        <= '0;
      word_idx   <= '0;
    end else begin
      byte_ready <= (next == LD_HDR_LO) || (next == LD_HDR_HI) || (next == LD_DATA);
      mem_we     <= (next == LD_WRITE);
      if (state == LD_HDR_LO && accept) cnt_lo <= byte_in;
      if (pk_clear) begin
        cnt      <= hdr_cnt;
        word_idx <= '0;
      end
      if (pk_load && pk_full) begin
        mem_addr  <= ADDR_W'(word_idx + (ADDR_W+1)'(BASE));
        mem_wdata <= pk_word;
      end
      if (state == LD_WRITE) word_idx <= word_idx + 1'b1;
    end
  end

  assign done       = (state == LD_DONE);
  assign err        = (state == LD_ERR);
  assign core_rst_n = (state == LD_DONE);

endmodule

// File: tb/tb_farm_imem_loader.sv
// Randomized scoreboard bench for farm_imem_loader.
module tb_farm_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int BASE   = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] byte_in = '0;
  logic byte_valid = 1'b0;
  logic byte_ready, mem_we, core_rst_n, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;

  farm_imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst_n(core_rst_n),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int total = 0;
  int passed = 0;
  wr_t exp_q[$];
  logic [31:0] stim_words[$];
  logic [31:0] act_mem [DEPTH];
  wr_t mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(mem_addr), 32'hffff_ffff);
      end else begin
        mon_w = exp_q.pop_front();
        check("we_addr", 32'(mem_addr), 32'(mon_w.addr));
        check("we_data", mem_wdata, mon_w.data);
      end
      act_mem[mem_addr] = mem_wdata;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    repeat ($urandom_range(0, max_gap)) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in = b;
    n = 0;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("byte_timeout", 32'(n), 32'd0);
    else @(posedge clk);
  endtask

  task automatic do_start(input bit with_valid, input logic [7:0] first);
    @(negedge clk);
    start = 1'b1;
    if (with_valid) begin
      byte_valid = 1'b1;
      byte_in = first;
    end
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b0;
    // One cycle after start the loader is in the header phase, core held in reset.
    check("start_core_rst_low", 32'(core_rst_n), 32'd0);
    check("start_done_low", 32'(done), 32'd0);
  endtask

  task automatic fill_random(input int cnt);
    stim_words.delete();
    for (int i = 0; i < cnt; i++) stim_words.push_back($urandom);
  endtask

  task automatic fill_test2();
    stim_words.delete();
    stim_words.push_back(32'h0000_0013);
    stim_words.push_back(32'h0010_0093);
  endtask

  // Reference: the stream is a count then words; every word lands at BASE+i
  // if the count fits in memory, otherwise nothing is written.
  task automatic run_load(input int cnt, input int max_gap, input bit with_valid);
    bit ok;
    int n;
    logic [15:0] c16;
    logic [31:0] w;
    c16 = 16'(cnt);
    ok = (cnt <= DEPTH);
    foreach (act_mem[i]) act_mem[i] = 'x;
    if (ok)
      for (int i = 0; i < cnt; i++) exp_q.push_back('{addr: ADDR_W'(BASE + i), data: stim_words[i]});
    do_start(with_valid, c16[7:0]);
    send_byte(c16[7:0], max_gap);
    send_byte(c16[15:8], max_gap);
    if (ok) begin
      for (int i = 0; i < cnt; i++) begin
        w = stim_words[i];
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (cnt == 0) check("empty_done_next", 32'(done), 32'd1);
    if (!ok) check("ovf_err_next", 32'(err), 32'd1);
    n = 0;
    while (!(done || err) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("end_done", 32'(done), 32'(ok));
    check("end_err", 32'(err), 32'(!ok));
    check("end_core_rst_n", 32'(core_rst_n), 32'(ok));
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (ok)
      for (int i = 0; i < cnt; i++) check("fetch_word", act_mem[ADDR_W'(BASE + i)], stim_words[i]);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready_low", 32'(byte_ready), 32'd0);

    fill_test2();
    run_load(2, 0, 1'b1);

    stim_words.delete();
    run_load(0, 0, 1'b0);

    run_load(257, 0, 1'b0);
    fill_random(3);
    run_load(3, 1, 1'b0);

    fill_test2();
    run_load(2, 3, 1'b0);

    // Abort mid-word: two data bytes then reset.
    do_start(1'b0, 8'h00);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready", 32'(byte_ready), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_core", 32'(core_rst_n), 32'd0);
    check("midrst_wdata", mem_wdata, 32'd0);
    fill_test2();
    run_load(2, 2, 1'b0);

    for (int r = 0; r < 4; r++) begin
      int c;
      c = $urandom_range(1, 6);
      fill_random(c);
      run_load(c, 2, 1'b0);
    end

    fill_random(DEPTH);
    run_load(DEPTH, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
